// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Optional per-requester grant statistics are enabled with DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int STAT_W     = 16;

    // Word accesses only: any set byte-offset bit is an alignment error.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requester after last_grant wins.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    // Scan from the farthest offset down so the nearest valid requester is written last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            int idx;
            idx = (int'(last_grant) + off) % NUM_REQ;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
                any        = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin sharing of a single-port data memory, one access in flight.
// Define DMEM_ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt).
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] grant_cnt
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    id_q, id_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;

    logic [NUM_REQ-1:0]  arb_grant_s;
    logic [IDX_W-1:0]    arb_idx_s;
    logic                arb_any_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic                sel_mis_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req        (req_valid),
        .last_grant (last_q),
        .grant      (arb_grant_s),
        .grant_idx  (arb_idx_s),
        .any        (arb_any_s)
    );

    assign sel_we_s   = req_we[arb_idx_s];
    assign sel_addr_s = req_addr[int'(arb_idx_s)*ADDR_W +: ADDR_W];
    assign sel_mis_s  = is_misaligned(sel_addr_s[1:0]);

    assign req_ready = (state_q == ST_IDLE) ? arb_grant_s : {NUM_REQ{1'b0}};
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Next-state and registered-output computation for the access FSM.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        last_d      = last_q;
        we_d        = we_q;
        err_d       = err_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any_s) begin
                    state_d     = ST_ACCESS;
                    id_d        = arb_idx_s;
                    last_d      = arb_idx_s;
                    we_d        = sel_we_s;
                    addr_d      = sel_addr_s;
                    wdata_d     = req_wdata[int'(arb_idx_s)*DATA_W +: DATA_W];
                    err_d       = sel_mis_s;
                    rdata_d     = '0;
                    mem_read_d  = !sel_we_s && !sel_mis_s;
                    mem_write_d = sel_we_s && !sel_mis_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // Only a strobed load captures memory data; stores and errors answer 0.
                rdata_d              = mem_read_q ? mem_rdata : {DATA_W{1'b0}};
                rsp_valid_d          = '0;
                rsp_valid_d[id_q]    = 1'b1;
                state_d              = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[id_q]) begin
                    rsp_valid_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                rsp_valid_d = '0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            id_q        <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            last_q      <= last_d;
            we_q        <= we_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [NUM_REQ*STAT_W-1:0] cnt_q, cnt_d;

    // Count every accepted request against its requester.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE && arb_any_s) begin
            cnt_d[int'(arb_idx_s)*STAT_W +: STAT_W] =
                sat_inc(cnt_q[int'(arb_idx_s)*STAT_W +: STAT_W]);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: vector table, corner sequences, random traffic.
module tb_dmem_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid, rsp_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
    logic            rsp_err, mem_read, mem_write;
    logic [AW-1:0]   mem_addr;
`ifdef DMEM_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    dmem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    // Memory seen by the DUT: combinational read, posedge write.
    logic [31:0] mem [64];
    bit          mem_init = 1'b1;
    int          wr20_cnt = 0;
    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= (i == 4) ? 32'hDEADBEEF : 32'h0;
        end else if (mem_write) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
        if (!mem_init && mem_write && mem_addr == 32'h20) wr20_cnt <= wr20_cnt + 1;
    end

    // Reference model state
    logic [31:0] ref_mem [64];
    int          rr_ptr;
    int          exp_cnt [N];
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        int          id;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] v);
        for (int off = 1; off <= N; off++) begin
            if (v[(rr_ptr + off) % N]) return (rr_ptr + off) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int id, input bit we, input logic [31:0] a, input logic [31:0] d);
        req_we[id]              = we;
        req_addr[id*AW +: AW]   = a;
        req_wdata[id*DW +: DW]  = d;
        req_valid[id]           = 1'b1;
    endtask

    // One complete access; called at a negedge with the DUT idle and requests driven.
    task automatic txn(input int bp, output int g, output logic [31:0] rdata, output logic err);
        logic [31:0] a, d, exp_data;
        bit          we, al;
        logic [N-1:0] oh;
        g = model_grant(req_valid);
        if (g < 0) g = 0;
        we = req_we[g];
        a  = req_addr[g*AW +: AW];
        d  = req_wdata[g*DW +: DW];
        al = (a[1:0] == 2'b00);
        oh = '0;
        oh[g] = 1'b1;
        exp_data = (!we && al) ? ref_mem[a[7:2]] : 32'h0;
        #1;
        chk("accept_ready", req_ready, oh);
        @(posedge clk);
        rr_ptr = g;
        exp_cnt[g]++;
        if (we && al) ref_mem[a[7:2]] = d;
        @(negedge clk);
        req_valid[g] = 1'b0;
        #1;
        chk("access_mem_read", mem_read, !we && al);
        chk("access_mem_write", mem_write, we && al);
        chk("access_mem_addr", mem_addr, a);
        if (we) chk("access_mem_wdata", mem_wdata, d);
        chk("access_req_ready", req_ready, 0);
        chk("access_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        #1;
        chk("rsp_valid", rsp_valid, oh);
        chk("rsp_rdata", rsp_rdata, exp_data);
        chk("rsp_err", rsp_err, !al);
        chk("rsp_strobes", {mem_read, mem_write}, 0);
        chk("rsp_req_ready", req_ready, 0);
        rdata = rsp_rdata;
        err   = rsp_err;
        for (int k = 0; k < bp; k++) begin
            rsp_ready = ~oh;
            @(negedge clk);
            #1;
            chk("bp_rsp_valid", rsp_valid, oh);
            chk("bp_rsp_rdata", rsp_rdata, exp_data);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_strobes", {mem_read, mem_write}, 0);
        end
        rsp_ready = oh;
        @(negedge clk);
        rsp_ready = '0;
    endtask

    task automatic apply_reset();
        req_valid = '0;
        rsp_ready = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_strobes", {mem_read, mem_write}, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
`ifdef DMEM_ARB_STATS_EN
        chk("rst_grant_cnt", grant_cnt, 0);
`endif
        rr_ptr = N - 1;
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          g;
        logic [31:0] rd;
        logic        er;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; rsp_ready = '0;
        rst_n = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = (i == 4) ? 32'hDEADBEEF : 32'h0;
        tbl[0] = '{0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[1] = '{1, 1'b1, 32'h20, 32'h12345678, 32'h0,        1'b0};
        tbl[2] = '{1, 1'b0, 32'h20, 32'h0,        32'h12345678, 1'b0};
        tbl[3] = '{0, 1'b0, 32'h13, 32'h0,        32'h0,        1'b1};
        tbl[4] = '{1, 1'b1, 32'h22, 32'hCAFEF00D, 32'h0,        1'b1};
        tbl[5] = '{0, 1'b1, 32'h04, 32'hA5A55A5A, 32'h0,        1'b0};
        tbl[6] = '{0, 1'b0, 32'h04, 32'h0,        32'hA5A55A5A, 1'b0};
        tbl[7] = '{1, 1'b0, 32'h20, 32'h0,        32'h12345678, 1'b0};
        @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        apply_reset();

        // Directed vectors, one requester at a time
        for (int v = 0; v < 8; v++) begin
            set_req(tbl[v].id, tbl[v].we, tbl[v].addr, tbl[v].wdata);
            txn(0, g, rd, er);
            chk("vec_grant", g, tbl[v].id);
            chk("vec_rdata", rd, tbl[v].exp_rdata);
            chk("vec_err", er, tbl[v].exp_err);
        end
        chk("store_0x20_write_count", wr20_cnt, 1);

        // Backpressure with both requesters waiting; last grant was req1
        set_req(0, 1'b0, 32'h10, 32'h0);
        set_req(1, 1'b0, 32'h20, 32'h0);
        txn(5, g, rd, er);
        chk("bp_grant", g, 0);
        chk("bp_rdata_final", rd, 32'hDEADBEEF);
        txn(0, g, rd, er);
        chk("bp_next_grant", g, 1);

        // Contention from reset: strict alternation
        apply_reset();
        set_req(0, 1'b0, 32'h10, 32'h0);
        set_req(1, 1'b1, 32'h08, 32'h11110000);
        for (int k = 0; k < 6; k++) begin
            txn(0, g, rd, er);
            chk("contention_order", g, k % 2);
            set_req(g, $urandom_range(0, 1), 32'($urandom_range(0, 14)) << 2, $urandom);
        end
        req_valid = '0;

        // Reset during ACCESS of a store to word 15 (not checked afterwards)
        set_req(1, 1'b1, 32'h3C, 32'h55AA55AA);
        #1;
        chk("mid_rst_accept", req_ready, 2'b10);
        @(posedge clk);
        #2;
        chk("mid_rst_pre_write", mem_write, 1);
        apply_reset();
        set_req(0, 1'b0, 32'h10, 32'h0);
        set_req(1, 1'b0, 32'h10, 32'h0);
        txn(0, g, rd, er);
        chk("post_rst_grant", g, 0);

        // Random traffic against the reference model
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < N; r++) begin
                if (!req_valid[r] && $urandom_range(0, 1) == 1) begin
                    logic [31:0] a;
                    a = 32'($urandom_range(0, 14)) << 2;
                    if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
                    set_req(r, $urandom_range(0, 1), a, $urandom);
                end
            end
            if (req_valid == '0) set_req($urandom_range(0, N - 1), 1'b0, 32'h10, 32'h0);
            txn($urandom_range(0, 3), g, rd, er);
        end
        req_valid = '0;

`ifdef DMEM_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("grant_cnt", grant_cnt[i*16 +: 16], exp_cnt[i]);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
